// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Streams a program image into the writable port of the instruction
//   memory and holds the CPU in stall until the whole image has landed.
//   Words arrive on a valid/ready handshake. Each accepted word is written
//   exactly one cycle later to a word-aligned byte address. The address
//   starts at the latched base and advances by 4 for every word.
//
// Ports
//   clk, reset_n       clock, synchronous active-low reset
//   start              one-cycle pulse: latch base_addr/word_count, begin load
//   abort              cancel an in-progress load (back to IDLE)
//   base_addr          byte address of first word (must be 4-byte aligned)
//   word_count         number of 32-bit words in the image
//   in_valid/in_ready  word handshake; in_data is the instruction word
//   mem_we/mem_addr/mem_wdata  instruction-memory write port
//   busy/done/error    registered state decodes (LOAD / DONE / ERROR)
//   words_written      words accepted in the current load
//   checksum           running XOR of the accepted words
//   cpu_hold           CPU stall, low only once a load has completed
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int INSTRUCT_MEM_SIZE = 1024,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [63:0]      base_addr,
   input  logic [CNT_W-1:0] word_count,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             mem_we,
   output logic [63:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] words_written,
   output logic [31:0]      checksum,
   output logic             cpu_hold
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   // The end-of-image bound is evaluated in 66 bits so that neither a huge
   // base address nor a huge word count can wrap around and sneak past it.
   localparam logic [65:0] MEM_SIZE_W = 66'(INSTRUCT_MEM_SIZE);

   state_t             state_q, state_d;

   logic [63:0]        addr_q, addr_d;       // next write address
   logic [CNT_W-1:0]   total_q, total_d;     // latched word_count
   logic [CNT_W-1:0]   wcnt_q, wcnt_d;
   logic [31:0]        csum_q, csum_d;

   logic               in_ready_q, in_ready_d;
   logic               mem_we_q, mem_we_d;
   logic [63:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic               cpu_hold_q, cpu_hold_d;

   logic               start_ok;             // start honoured in this state
   logic               accept;
   logic               last_word;
   logic               misaligned;
   logic               out_of_bounds;
   logic [65:0]        end_addr;

   // ------------------------------------------------------------------
   // Handshake / start qualification
   // ------------------------------------------------------------------
   assign start_ok  = start && (state_q != S_LOAD);
   assign accept    = (state_q == S_LOAD) && in_ready_q && in_valid;
   assign last_word = (({1'b0, wcnt_q} + 1'b1) == {1'b0, total_q});

   assign misaligned    = (base_addr[1:0] != 2'b00);
   assign end_addr      = {2'b00, base_addr}
                        + ({{(66-CNT_W){1'b0}}, word_count} << 2);
   assign out_of_bounds = (end_addr > MEM_SIZE_W);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_LOAD: begin
            // abort beats both a completing accept and a stray start
            if (abort) begin
               state_d = S_IDLE;
            end else if (accept && last_word) begin
               state_d = S_DONE;
            end
         end
         default: begin
            if (start) begin
               if (misaligned) begin
                  state_d = S_ERROR;
               end else if (out_of_bounds) begin
                  state_d = S_ERROR;
               end else if (word_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output / datapath next-state logic
   // Status outputs decode state_d so the registered copy lines up with
   // the state register itself.
   // ------------------------------------------------------------------
   always_comb begin
      addr_d      = addr_q;
      total_d     = total_q;
      wcnt_d      = wcnt_q;
      csum_d      = csum_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      // One write per accept, one cycle later; an accept in the same cycle
      // as abort is still written.
      mem_we_d    = accept;

      if (start_ok) begin
         addr_d  = base_addr;
         total_d = word_count;
         wcnt_d  = '0;
         csum_d  = '0;
      end

      if (accept) begin
         mem_addr_d  = addr_q;
         mem_wdata_d = in_data;
         addr_d      = addr_q + 64'd4;
         wcnt_d      = wcnt_q + 1'b1;
         csum_d      = csum_q ^ in_data;
      end

      // Dropping in_ready on the final accept prevents a word beyond the
      // image from being taken.
      in_ready_d = (state_d == S_LOAD);
      busy_d     = (state_d == S_LOAD);
      done_d     = (state_d == S_DONE);
      error_d    = (state_d == S_ERROR);
      cpu_hold_d = (state_d != S_DONE);
   end

   // ------------------------------------------------------------------
   // Datapath / output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_q      <= '0;
         total_q     <= '0;
         wcnt_q      <= '0;
         csum_q      <= '0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         cpu_hold_q  <= 1'b1;
      end else begin
         addr_q      <= addr_d;
         total_q     <= total_d;
         wcnt_q      <= wcnt_d;
         csum_q      <= csum_d;
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         cpu_hold_q  <= cpu_hold_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign words_written = wcnt_q;
   assign checksum      = csum_q;
   assign cpu_hold      = cpu_hold_q;

   // ------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------
   a_addr_aligned : assert property (@(posedge clk) disable iff (!reset_n)
      mem_we |-> (mem_addr[1:0] == 2'b00));

   a_no_write_in_error : assert property (@(posedge clk) disable iff (!reset_n)
      (error && $past(error)) |-> !mem_we);

   a_hold_unless_done : assert property (@(posedge clk) disable iff (!reset_n)
      (cpu_hold == !done));

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int CNT_W = 16;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic             abort;
   logic [63:0]      base_addr;
   logic [CNT_W-1:0] word_count;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             mem_we;
   logic [63:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] words_written;
   logic [31:0]      checksum;
   logic             cpu_hold;

   imem_loader #(.INSTRUCT_MEM_SIZE(1024), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .abort         (abort),
      .base_addr     (base_addr),
      .word_count    (word_count),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .words_written (words_written),
      .checksum      (checksum),
      .cpu_hold      (cpu_hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // write log, sampled mid-cycle
   logic [63:0] wr_addr [0:31];
   logic [31:0] wr_data [0:31];
   int          wr_cyc  [0:31];
   int          n_wr = 0;

   always @(negedge clk) begin
      if (mem_we && n_wr < 32) begin
         wr_addr[n_wr] = mem_addr;
         wr_data[n_wr] = mem_wdata;
         wr_cyc[n_wr]  = cyc;
         n_wr          = n_wr + 1;
      end
   end

   // accept log filled by the stimulus side
   logic [31:0] acc_data [0:31];
   int          acc_cyc  [0:31];
   int          n_acc;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // called at #1 after a posedge; the start pulse is sampled at the next edge
   task automatic do_start(input logic [63:0] b, input int cnt);
      start      = 1'b1;
      base_addr  = b;
      word_count = CNT_W'(cnt);
      tick(1);
      start      = 1'b0;
   endtask

   // present one word, wait for it to be taken, then idle for gap cycles
   task automatic send(input logic [31:0] w, input int gap);
      int bound;
      in_valid = 1'b1;
      in_data  = w;
      bound    = 0;
      while (!in_ready && bound < 20) begin
         tick(1);
         bound++;
      end
      if (!in_ready) begin
         chk("ready_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
      end else begin
         tick(1);
         acc_data[n_acc] = w;
         acc_cyc[n_acc]  = cyc;
         n_acc++;
         in_valid = 1'b0;
         if (gap > 0) tick(gap);
      end
   endtask

   // each write: address base+4i, data of accept i, in the cycle right after it
   task automatic verify_writes(input string tag, input int first, input int n,
                                input logic [63:0] b);
      chk({tag, "_nwr"}, 64'(n_wr - first), 64'(n));
      for (int i = 0; i < n; i++) begin
         chk({tag, "_addr"}, wr_addr[first+i], b + 64'(4*i));
         chk({tag, "_data"}, 64'(wr_data[first+i]), 64'(acc_data[i]));
         chk({tag, "_lat"},  64'(wr_cyc[first+i]), 64'(acc_cyc[i]));
      end
   endtask

   task automatic expect_error(input string tag, input logic [63:0] b, input int cnt);
      int first;
      first = n_wr;
      do_start(b, cnt);
      chk({tag, "_error"}, 64'(error), 64'd1);
      chk({tag, "_hold"},  64'(cpu_hold), 64'd1);
      chk({tag, "_busy"},  64'(busy), 64'd0);
      tick(3);
      chk({tag, "_error_sticky"}, 64'(error), 64'd1);
      chk({tag, "_nowr"}, 64'(n_wr - first), 64'd0);
   endtask

   int first;

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      n_acc      = 0;
      tick(2);

      // ---- reset state
      chk("rst_we",    64'(mem_we), 64'd0);
      chk("rst_addr",  mem_addr, 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_ww",    64'(words_written), 64'd0);
      chk("rst_csum",  64'(checksum), 64'd0);
      chk("rst_hold",  64'(cpu_hold), 64'd1);
      reset_n = 1'b1;
      tick(2);

      // ---- basic back-to-back load
      first = n_wr;
      n_acc = 0;
      do_start(64'd0, 3);
      chk("basic_busy",  64'(busy), 64'd1);
      chk("basic_ready", 64'(in_ready), 64'd1);
      send(32'h9100_0421, 0);
      send(32'h9100_0842, 0);
      send(32'h1400_0000, 0);
      // first DONE cycle carries the last write
      chk("basic_done",     64'(done), 64'd1);
      chk("basic_last_we",  64'(mem_we), 64'd1);
      chk("basic_ready_lo", 64'(in_ready), 64'd0);
      chk("basic_hold",     64'(cpu_hold), 64'd0);
      chk("basic_ww",       64'(words_written), 64'd3);
      // 0x91000421 ^ 0x91000842 ^ 0x14000000
      chk("basic_csum",     64'(checksum), 64'h1400_0C63);
      tick(3);
      verify_writes("basic", first, 3, 64'd0);
      chk("basic_done_hold", 64'(done), 64'd1);

      // ---- restart from DONE with 2-cycle gaps between words
      first = n_wr;
      n_acc = 0;
      do_start(64'd0, 3);
      chk("gap_done_clr", 64'(done), 64'd0);
      chk("gap_busy",     64'(busy), 64'd1);
      chk("gap_hold",     64'(cpu_hold), 64'd1);
      chk("gap_ww_clr",   64'(words_written), 64'd0);
      send(32'h9100_0421, 2);
      chk("gap_ww1",      64'(words_written), 64'd1);
      send(32'h9100_0842, 2);
      send(32'h1400_0000, 0);
      tick(4);
      verify_writes("gap", first, 3, 64'd0);
      chk("gap_done", 64'(done), 64'd1);
      chk("gap_csum", 64'(checksum), 64'h1400_0C63);

      // ---- alignment / bounds errors
      expect_error("err_align", 64'd2, 1);
      expect_error("err_end",   64'd1020, 2);
      expect_error("err_count", 64'd0, 257);

      // ---- exact fit at the top of memory, started from ERROR
      first = n_wr;
      n_acc = 0;
      do_start(64'd1020, 1);
      chk("fit_err_clr", 64'(error), 64'd0);
      send(32'hCAFE_F00D, 0);
      chk("fit_done", 64'(done), 64'd1);
      tick(2);
      verify_writes("fit", first, 1, 64'd1020);

      // ---- zero-length image
      first = n_wr;
      do_start(64'h40, 0);
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_hold", 64'(cpu_hold), 64'd0);
      chk("zero_ww",   64'(words_written), 64'd0);
      tick(3);
      chk("zero_nowr", 64'(n_wr - first), 64'd0);

      // ---- abort after two accepts; start during LOAD is ignored
      first = n_wr;
      n_acc = 0;
      do_start(64'h100, 4);
      send(32'hA000_0001, 0);
      do_start(64'd2, 1);
      chk("ign_busy",  64'(busy), 64'd1);
      chk("ign_error", 64'(error), 64'd0);
      chk("ign_ww",    64'(words_written), 64'd1);
      send(32'hA000_0002, 1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("abort_busy",  64'(busy), 64'd0);
      chk("abort_done",  64'(done), 64'd0);
      chk("abort_error", 64'(error), 64'd0);
      chk("abort_ready", 64'(in_ready), 64'd0);
      chk("abort_hold",  64'(cpu_hold), 64'd1);
      tick(3);
      verify_writes("abort", first, 2, 64'h100);
      chk("abort_idle", 64'(busy), 64'd0);

      // ---- reset in the middle of a load
      first = n_wr;
      n_acc = 0;
      do_start(64'd0, 3);
      send(32'h1111_2222, 0);
      // second word offered while reset is asserted must not be taken
      reset_n  = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h3333_4444;
      tick(1);
      chk("mrst_we",    64'(mem_we), 64'd0);
      chk("mrst_addr",  mem_addr, 64'd0);
      chk("mrst_wdata", 64'(mem_wdata), 64'd0);
      chk("mrst_ready", 64'(in_ready), 64'd0);
      chk("mrst_busy",  64'(busy), 64'd0);
      chk("mrst_done",  64'(done), 64'd0);
      chk("mrst_error", 64'(error), 64'd0);
      chk("mrst_ww",    64'(words_written), 64'd0);
      chk("mrst_csum",  64'(checksum), 64'd0);
      chk("mrst_hold",  64'(cpu_hold), 64'd1);
      in_valid = 1'b0;
      reset_n  = 1'b1;
      tick(4);
      chk("mrst_nwr",  64'(n_wr - first), 64'd1);
      chk("mrst_idle", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
